// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter that time-shares one signed Booth multiplier.
// IDLE grants and captures, CALC registers the product, HOLD returns it.
module booth_mul_arbiter #(
   parameter int M_SIZE = 4,
   parameter int R_SIZE = 4,
   parameter int N_REQ  = 4,
   parameter int ID_W   = $clog2(N_REQ)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*M_SIZE-1:0]    req_m,
   input  logic [N_REQ*R_SIZE-1:0]    req_r,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [M_SIZE+R_SIZE-1:0]   rsp_res,
   output logic [ID_W-1:0]            rsp_id
);

   localparam int P_W = M_SIZE + R_SIZE;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      HOLD
   } state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [ID_W-1:0]     id_q, id_d;
   logic [ID_W-1:0]     rid_q, rid_d;
   logic [M_SIZE-1:0]   m_q, m_d;
   logic [R_SIZE-1:0]   r_q, r_d;
   logic [P_W-1:0]      res_q, res_d;

   logic                gnt_vld;
   logic [ID_W-1:0]     gnt;
   logic [M_SIZE-1:0]   m_sel;
   logic [R_SIZE-1:0]   r_sel;
   logic [ID_W:0]       idx;
   logic [P_W-1:0]      mx;
   logic [P_W-1:0]      acc;
   logic [R_SIZE:0]     rx;
   logic [P_W-1:0]      prod;

   // Rotating priority search starting at ptr; nearest valid requester wins.
   always_comb begin
      gnt_vld = 1'b0;
      gnt     = '0;
      idx     = '0;
      m_sel   = '0;
      r_sel   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = {1'b0, ptr_q} + (ID_W+1)'(k);
         if (idx >= (ID_W+1)'(N_REQ)) begin
            idx = idx - (ID_W+1)'(N_REQ);
         end
         if (req_valid[idx[ID_W-1:0]]) begin
            gnt_vld = 1'b1;
            gnt     = idx[ID_W-1:0];
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (ID_W'(i) == gnt) begin
            m_sel = req_m[i*M_SIZE +: M_SIZE];
            r_sel = req_r[i*R_SIZE +: R_SIZE];
         end
      end
   end

   // Radix-2 Booth datapath on the captured operands, full-width sign-extended.
   always_comb begin
      mx  = {{(P_W-M_SIZE){m_q[M_SIZE-1]}}, m_q};
      rx  = {r_q, 1'b0};
      acc = '0;
      for (int i = 0; i < R_SIZE; i++) begin
         case (rx[i +: 2])
            2'b01:   acc = acc + (mx << i);
            2'b10:   acc = acc - (mx << i);
            default: acc = acc;
         endcase
      end
      prod = acc;
   end

   // Sequencer next-state: grant and capture, compute, then hold the response.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      m_d     = m_q;
      r_d     = r_q;
      id_d    = id_q;
      res_d   = res_q;
      rid_d   = rid_q;
      unique case (state_q)
         IDLE: begin
            if (gnt_vld) begin
               m_d     = m_sel;
               r_d     = r_sel;
               id_d    = gnt;
               ptr_d   = (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + 1'b1;
               state_d = CALC;
            end
         end
         CALC: begin
            res_d   = prod;
            rid_d   = id_q;
            state_d = HOLD;
         end
         HOLD: begin
            if (rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         m_q     <= '0;
         r_q     <= '0;
         id_q    <= '0;
         res_q   <= '0;
         rid_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         m_q     <= m_d;
         r_q     <= r_d;
         id_q    <= id_d;
         res_q   <= res_d;
         rid_q   <= rid_d;
      end
   end

   assign req_ready = (rst_n && state_q == IDLE && gnt_vld)
                    ? (N_REQ'(1) << gnt) : '0;
   assign rsp_valid = (state_q == HOLD);
   assign rsp_res   = res_q;
   assign rsp_id    = rid_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: directed corners plus random traffic
// against a transaction-level scoreboard.
module tb_booth_mul_arbiter;

   localparam int N  = 4;
   localparam int MS = 4;
   localparam int RS = 4;
   localparam int PW = MS + RS;

   logic              clk;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*MS-1:0]   req_m;
   logic [N*RS-1:0]   req_r;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [PW-1:0]     rsp_res;
   logic [1:0]        rsp_id;

   logic [MS-1:0]     opm [N];
   logic [RS-1:0]     opr [N];

   int total = 0;
   int bad   = 0;

   int m_ptr;
   bit m_busy;
   int m_cnt;
   logic [PW-1:0] m_res;
   int m_id;
   int glog[$];
   int gcyc[$];
   int cyc;
   bit done;
   logic [PW-1:0] last_res;
   int last_id;
   int hs;

   booth_mul_arbiter #(
      .M_SIZE(MS),
      .R_SIZE(RS),
      .N_REQ (N)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_m    (req_m),
      .req_r    (req_r),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_res  (rsp_res),
      .rsp_id   (rsp_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      req_m = '0;
      req_r = '0;
      for (int i = 0; i < N; i++) begin
         req_m[i*MS +: MS] = opm[i];
         req_r[i*RS +: RS] = opr[i];
      end
   end

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] ref_mul(logic [MS-1:0] a,
                                             logic [RS-1:0] b);
      int x;
      int y;
      int p;
      x = $signed(a);
      y = $signed(b);
      p = x * y;
      return p[PW-1:0];
   endfunction

   function automatic int model_grant();
      int j;
      if (!rst_n) return -1;
      for (int k = 0; k < N; k++) begin
         j = (m_ptr + k) % N;
         if (req_valid[j]) return j;
      end
      return -1;
   endfunction

   // One cycle: check outputs vs scoreboard, advance model, cross an edge.
   task automatic step();
      int g;
      logic [N-1:0] er;
      bit ev;
      #1;
      done = 0;
      hs   = -1;
      g    = m_busy ? -1 : model_grant();
      er   = (g >= 0) ? (N'(1) << g) : '0;
      ev   = m_busy && m_cnt == 2;
      chk("req_ready", 32'(req_ready), 32'(er));
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      if (ev) begin
         chk("rsp_res", 32'(rsp_res), 32'(m_res));
         chk("rsp_id", 32'(rsp_id), m_id);
      end
      if (g >= 0) begin
         hs     = g;
         m_busy = 1;
         m_cnt  = 1;
         m_res  = ref_mul(opm[g], opr[g]);
         m_id   = g;
         m_ptr  = (g + 1) % N;
         glog.push_back(g);
         gcyc.push_back(cyc);
      end else if (m_busy) begin
         if (m_cnt == 2) begin
            if (rsp_ready) begin
               m_busy   = 0;
               done     = 1;
               last_res = rsp_res;
               last_id  = rsp_id;
            end
         end else begin
            m_cnt++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      m_busy = 0;
      m_ptr  = 0;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_res", 32'(rsp_res), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      @(negedge clk);
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic run_one(string tag, int i, logic [MS-1:0] m,
                          logic [RS-1:0] r, logic [PW-1:0] exp);
      req_valid    = '0;
      req_valid[i] = 1'b1;
      opm[i]       = m;
      opr[i]       = r;
      rsp_ready    = 1'b1;
      done         = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (hs >= 0) req_valid = '0;
         if (done) break;
      end
      chk({tag, "_done"}, 32'(done), 1);
      chk(tag, 32'(last_res), 32'(exp));
      chk({tag, "_id"}, last_id, i);
   endtask

   initial begin
      rst_n     = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      hs        = -1;
      cyc       = 0;
      for (int i = 0; i < N; i++) begin
         opm[i] = '0;
         opr[i] = '0;
      end
      #2;
      req_valid = '1;
      do_reset();

      run_one("m3r5", 0, 4'd3, 4'd5, 8'h0F);
      run_one("m8rF", 1, 4'b1000, 4'b1111, 8'h08);
      run_one("m7r8", 2, 4'b0111, 4'b1000, 8'hC8);
      run_one("m8r8", 3, 4'b1000, 4'b1000, 8'h40);
      run_one("m0rF", 0, 4'b0000, 4'b1111, 8'h00);

      do_reset();
      for (int i = 0; i < N; i++) begin
         opm[i] = 4'($urandom);
         opr[i] = 4'($urandom);
      end
      req_valid = '1;
      rsp_ready = 1'b1;
      glog.delete();
      gcyc.delete();
      for (int c = 0; c < 14; c++) step();
      chk("rr_count", 32'(glog.size() >= 5), 1);
      for (int i = 0; i < 5; i++) chk("rr_order", glog[i], i % N);
      for (int i = 1; i < 5; i++) chk("rr_gap", gcyc[i] - gcyc[i-1], 3);

      req_valid = '1;
      rsp_ready = 1'b0;
      for (int c = 0; c < 8 && !(m_busy && m_cnt == 2); c++) step();
      chk("bp_hold", 32'(m_busy && m_cnt == 2), 1);
      begin
         logic [PW-1:0] sres;
         logic [1:0] sid;
         sres = rsp_res;
         sid  = rsp_id;
         for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_res", 32'(rsp_res), 32'(sres));
            chk("bp_id", 32'(rsp_id), 32'(sid));
         end
      end
      rsp_ready = 1'b1;
      step();
      chk("bp_done", 32'(done), 1);
      step();
      chk("bp_next", 32'(hs >= 0), 1);
      for (int c = 0; c < 3; c++) step();

      do_reset();
      run_one("w0", 0, 4'd1, 4'd2, 8'h02);
      run_one("w1", 1, 4'd2, 4'd3, 8'h06);
      run_one("w2", 2, 4'd3, 4'd3, 8'h09);
      run_one("w3", 1, 4'hF, 4'hF, 8'h01);
      chk("wrap_g", glog[$], 1);
      req_valid = '1;
      for (int c = 0; c < 4 && hs < 0; c++) step();
      chk("wrap_ptr", hs, 2);
      for (int c = 0; c < 3; c++) step();

      do_reset();
      req_valid = '1;
      rsp_ready = 1'b1;
      step();
      chk("mr_first", hs, 0);
      rst_n  = 1'b0;
      m_busy = 0;
      m_ptr  = 0;
      #1;
      chk("mr_valid", 32'(rsp_valid), 0);
      @(negedge clk);
      step();
      step();
      rst_n = 1'b1;
      step();
      chk("mr_regrant", hs, 0);
      for (int c = 0; c < 4; c++) step();

      do_reset();
      req_valid = '0;
      hs        = -1;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || hs == i) begin
               req_valid[i] = 1'($urandom_range(0, 1));
               opm[i]       = 4'($urandom);
               opr[i]       = 4'($urandom);
            end else if ($urandom_range(0, 9) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
